// File: rtl/os_msg_pkg.sv
// Shared definitions for the kernel message channel: display FSM states,
// FIFO entry width and the message codes emitted by the environment-variables block.
package os_msg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SHOW = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam int unsigned MSG_ENTRY_W = 10;

    localparam logic [4:0] MSG_NONE    = 5'd0;
    localparam logic [4:0] MSG_ENV_SET = 5'd1;
    localparam logic [4:0] MSG_ENV_GET = 5'd2;
    localparam logic [4:0] MSG_ENV_DEL = 5'd3;
    localparam logic [4:0] MSG_ENV_ERR = 5'd31;

    // Entry layout: PID in the upper five bits, message code in the lower five.
    function automatic logic [MSG_ENTRY_W-1:0] pack_entry(input logic [4:0] pid,
                                                          input logic [4:0] code);
        return {pid, code};
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Synchronous single-write/single-read FIFO with full, empty and occupancy count.
// A read on a full FIFO frees the slot, so a write in the same cycle is accepted.
module msg_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/msg_receiver.sv
// Message channel consumer: edge-captures msg_sign, queues {pid, code} and shows each entry
// for HOLD_CYCLES followed by a GAP_CYCLES blank. MSG_RECEIVER_DUP_FILTER_EN drops repeats.
module msg_receiver
    import os_msg_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES  = 5000000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    msg_sign,
    input  logic [4:0]              msg_out,
    input  logic [4:0]              pid_in,
    input  logic                    skip,
    output logic                    disp_valid,
    output logic [4:0]              disp_code,
    output logic [4:0]              disp_pid,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [AW:0]      ONE_ENTRY = (AW+1)'(1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   msg_sign_q;
    logic [MSG_ENTRY_W-1:0] entry;
    logic [MSG_ENTRY_W-1:0] head;
    logic                   accept;
    logic                   dup;
    logic                   push;
    logic                   pop;
    logic                   wr_ok;
    logic                   full;
    logic                   empty;

    assign entry  = pack_entry(pid_in, msg_out);
    assign accept = msg_sign & ~msg_sign_q;
    assign pop    = (state == IDLE) & ~empty;
    assign push   = accept & ~dup;
    assign wr_ok  = push & (~full | pop);

`ifdef MSG_RECEIVER_DUP_FILTER_EN
    logic [MSG_ENTRY_W-1:0] last_entry;
    logic                   last_queued;

    // The newest entry leaves the FIFO only when it is the sole occupant being popped.
    assign dup = last_queued & (entry == last_entry) & ~(pop & (pending == ONE_ENTRY));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_entry  <= '0;
            last_queued <= 1'b0;
        end else if (wr_ok) begin
            last_entry  <= entry;
            last_queued <= 1'b1;
        end else if (pop && pending == ONE_ENTRY) begin
            last_queued <= 1'b0;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_sign_q <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            msg_sign_q <= msg_sign;
            if (push && !wr_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            disp_valid <= 1'b0;
            disp_code  <= '0;
            disp_pid   <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    disp_valid <= 1'b1;
                    disp_code  <= head[4:0];
                    disp_pid   <= head[MSG_ENTRY_W-1:5];
                    cnt        <= HOLD_LD;
                    state      <= SHOW;
                end
                SHOW: if (skip || cnt == CNT_ONE) begin
                    disp_valid <= 1'b0;
                    disp_code  <= '0;
                    disp_pid   <= '0;
                    cnt        <= GAP_LD;
                    state      <= GAP;
                end else begin
                    cnt <= cnt - CNT_ONE;
                end
                GAP: if (cnt == CNT_ONE) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt - CNT_ONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    msg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MSG_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (pending)
    );

endmodule

// File: tb/tb_msg_receiver.sv
// Bench for msg_receiver (DEPTH=4, HOLD=4, GAP=2): vector table, directed corner
// sequences and random traffic checked against a queue/timeline reference model.
module tb_msg_receiver;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       msg_sign;
    logic [4:0] msg_out;
    logic [4:0] pid_in;
    logic       skip;
    logic       disp_valid;
    logic [4:0] disp_code;
    logic [4:0] disp_pid;
    logic [2:0] pending;
    logic       overflow;

    always #5 clk = ~clk;

    msg_receiver #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .CNT_W       (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .msg_sign   (msg_sign),
        .msg_out    (msg_out),
        .pid_in     (pid_in),
        .skip       (skip),
        .disp_valid (disp_valid),
        .disp_code  (disp_code),
        .disp_pid   (disp_pid),
        .pending    (pending),
        .overflow   (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of waiting entries plus a display timeline in edge numbers.
    logic [9:0] mq[$];
    int         n = 0;
    int         m_ready;
    int         m_pop_edge;
    bit         m_show;
    logic [4:0] m_code;
    logic [4:0] m_pid;
    bit         m_ovf;
    bit         m_prev;

    logic [4:0] shown[$];
    bit         prev_valid;

    typedef struct {
        logic       s;
        logic [4:0] c;
        logic [4:0] p;
        logic       k;
        logic       ev;
        logic [4:0] ec;
        logic [4:0] ep;
        int         epend;
        logic       eovf;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ready = n;
        m_show  = 0;
        m_code  = '0;
        m_pid   = '0;
        m_ovf   = 0;
        m_prev  = 0;
    endfunction

    function automatic void model_edge(input logic s, input logic [4:0] c,
                                       input logic [4:0] p, input logic k);
        logic [9:0] e;
        bit dup;
        n++;
        if (m_show) begin
            if (k || n == m_pop_edge + HOLD) begin
                m_show  = 0;
                m_code  = '0;
                m_pid   = '0;
                m_ready = n + GAP + 1;
            end
        end else if (n >= m_ready && mq.size() > 0) begin
            e          = mq.pop_front();
            m_show     = 1;
            m_pop_edge = n;
            m_code     = e[4:0];
            m_pid      = e[9:5];
        end
        if (s && !m_prev) begin
            dup = 0;
`ifdef MSG_RECEIVER_DUP_FILTER_EN
            dup = (mq.size() > 0) && (mq[$] == {p, c});
`endif
            if (!dup) begin
                if (mq.size() < DEPTH) mq.push_back({p, c});
                else m_ovf = 1;
            end
        end
        m_prev = s;
    endfunction

    task automatic step(input logic s, input logic [4:0] c, input logic [4:0] p, input logic k);
        msg_sign = s;
        msg_out  = c;
        pid_in   = p;
        skip     = k;
        @(posedge clk);
        model_edge(s, c, p, k);
        #1;
        chk("valid",    disp_valid, m_show);
        chk("code",     disp_code,  m_code);
        chk("pid",      disp_pid,   m_pid);
        chk("pending",  pending,    mq.size());
        chk("overflow", overflow,   m_ovf);
        if (disp_valid && !prev_valid) shown.push_back(disp_code);
        prev_valid = disp_valid;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        msg_sign = 1'b0;
        msg_out  = '0;
        pid_in   = '0;
        skip     = 1'b0;
        reset    = 1'b0;
        #1;
        chk("rst_valid",    disp_valid, 0);
        chk("rst_code",     disp_code,  0);
        chk("rst_pid",      disp_pid,   0);
        chk("rst_pending",  pending,    0);
        chk("rst_overflow", overflow,   0);
        @(posedge clk);
        n++;
        #1;
        reset = 1'b1;
        model_reset();
        prev_valid = 0;
        shown.delete();
    endtask

    function automatic vec_t mk(input logic s, input logic [4:0] c, input logic [4:0] p,
                                input logic ev, input logic [4:0] ec, input logic [4:0] ep,
                                input int epend);
        vec_t v;
        v.s = s; v.c = c; v.p = p; v.k = 1'b0;
        v.ev = ev; v.ec = ec; v.ep = ep; v.epend = epend; v.eovf = 1'b0;
        return v;
    endfunction

    initial begin
        int peak;
        int nfours;

        tbl[0] = mk(1'b1, 5'd3, 5'd2, 1'b0, 5'd0, 5'd0, 1);
        tbl[1] = mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 5'd2, 0);
        tbl[2] = mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 5'd2, 0);
        tbl[3] = mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 5'd2, 0);
        tbl[4] = mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 5'd2, 0);
        tbl[5] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 0);
        tbl[6] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 0);
        tbl[7] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 0);

        do_reset();

        // Single message: write, pop, four display cycles, then blank.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].s, tbl[i].c, tbl[i].p, tbl[i].k);
            chk($sformatf("tbl%0d_valid", i),   disp_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_code", i),    disp_code,  tbl[i].ec);
            chk($sformatf("tbl%0d_pid", i),     disp_pid,   tbl[i].ep);
            chk($sformatf("tbl%0d_pending", i), pending,    tbl[i].epend);
            chk($sformatf("tbl%0d_ovf", i),     overflow,   tbl[i].eovf);
        end

        // Held strobe counts once.
        do_reset();
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 5'd7, 5'd3, 1'b0);
            if (int'(pending) > peak) peak = int'(pending);
        end
        idle(12);
        chk("held_peak",  peak, 1);
        chk("held_shows", shown.size(), 1);
        if (shown.size() > 0) chk("held_code", shown[0], 7);

        // Overflow: prime with code 31, then codes 1..6 while the display is busy.
        do_reset();
        step(1'b1, 5'd31, 5'd0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);
        for (int code = 1; code <= 6; code++) begin
            step(1'b1, 5'(code), 5'd0, 1'b0);
            step(1'b0, 5'd0, 5'd0, 1'b0);
        end
        chk("ovf_set", overflow, 1);
        idle(45);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_shows", shown.size(), 6);
        for (int i = 1; i < 6 && i < shown.size(); i++)
            chk($sformatf("ovf_order%0d", i), shown[i], i);

        // Skip on the second display cycle.
        do_reset();
        step(1'b1, 5'd9, 5'd1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd10, 5'd1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1);
        chk("skip_fall", disp_valid, 0);
        idle(3);
        chk("skip_next_valid", disp_valid, 1);
        chk("skip_next_code",  disp_code, 10);
        idle(10);

        // Reset in the middle of a display with three entries waiting.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 5'(11 + i), 5'd2, 1'b0);
            step(1'b0, 5'd0, 5'd0, 1'b0);
        end
        chk("midrst_pending", pending, 3);
        chk("midrst_showing", disp_valid, 1);
        do_reset();
        step(1'b1, 5'd21, 5'd4, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);
        chk("postrst_valid", disp_valid, 1);
        chk("postrst_code",  disp_code, 21);
        idle(8);

        // Repeated message while the first copy is still queued.
        do_reset();
        step(1'b1, 5'd20, 5'd0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd4, 5'd1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd4, 5'd1, 1'b0);
`ifdef MSG_RECEIVER_DUP_FILTER_EN
        chk("dup_pending", pending, 1);
`else
        chk("dup_pending", pending, 2);
`endif
        idle(30);
        nfours = 0;
        foreach (shown[i]) if (shown[i] == 5'd4) nfours++;
`ifdef MSG_RECEIVER_DUP_FILTER_EN
        chk("dup_shows", nfours, 1);
`else
        chk("dup_shows", nfours, 2);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 2)),
                 5'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_receiver.md
Name: msg_receiver

Overview:
- Consumer end of the kernel message channel: captures each message emitted on msg_out/msg_sign by the environment-variables block, tagged with the current PID.
- Queues messages in a small FIFO and presents each one on the board display for a fixed hold time, with a blank gap between messages.
- Sits between the environment-variables block and the 7-segment/LED driver.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- HOLD_CYCLES, 50000000, clk cycles each message stays displayed; ≥1.
- GAP_CYCLES, 5000000, clk cycles of blank display between messages; ≥1.
- CNT_W, 26, width of the hold/gap counter; must hold max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- msg_sign  in  1  message strobe from the environment-variables block.
- msg_out  in  5  message code.
- pid_in  in  5  current PID, sampled with the message.
- skip  in  1  synchronous user request to end the current display early.
- disp_valid  out  1  display shows a message.
- disp_code  out  5  displayed message code.
- disp_pid  out  5  PID tag of the displayed message.
- pending  out  log2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a message was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, FSM in IDLE, counter 0, msg_sign_q 0. disp_valid=0, disp_code=0, disp_pid=0, pending=0, overflow=0.
- Capture: the block registers msg_sign_q each cycle. A message is accepted on a rising edge (msg_sign=1 and msg_sign_q=0). On acceptance, {pid_in, msg_out} is written to the FIFO. msg_sign held high across several cycles counts as one message.
- Full FIFO: an accepted message arriving while full is dropped and overflow is set. overflow clears only on reset.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head into the display registers, set disp_valid=1, load the counter, go to SHOW. Display latency from an accept into an empty FIFO in IDLE is 2 cycles (write, then pop).
  - SHOW: counter decrements each cycle. Leave SHOW after exactly HOLD_CYCLES cycles with disp_valid=1, or on the cycle after skip=1, whichever comes first. Then disp_valid=0 and disp_code/disp_pid are cleared to 0; go to GAP.
  - GAP: counter runs GAP_CYCLES cycles with disp_valid=0, then return to IDLE. skip is ignored in IDLE and GAP.
- Simultaneous push and pop on a full FIFO: the pop happens first, so the push is accepted and overflow is not set. pending stays unchanged.
- pending updates in the cycle after a push or pop and never exceeds DEPTH.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked with a separate counter.
- Reset asserted mid-SHOW or mid-GAP discards all queued and displayed messages immediately.

Optional Feature:
- Macro: MSG_RECEIVER_DUP_FILTER_EN.
- Defined: an accepted message whose {pid_in, msg_out} equals the most recently enqueued entry is discarded unless that entry has already been popped. It is neither stored nor counted as overflow.
- Not defined: every rising edge of msg_sign is enqueued, including duplicates.

Decomposition:
- Shared package os_msg_pkg holds:
  - the FSM state encoding (IDLE=2'b00, SHOW=2'b01, GAP=2'b10);
  - the entry width constant MSG_ENTRY_W=10;
  - message code constants shared with the environment-variables block.
- One sub-module, msg_fifo: synchronous FIFO with a single write port and a single read port, providing full, empty and count. msg_receiver instantiates it; the FSM, the edge detector and the optional filter stay in the top module.

Test Plan (DEPTH=4, HOLD_CYCLES=4, GAP_CYCLES=2):
- Single message: pulse msg_sign for 1 cycle with msg_out=5'd3, pid_in=5'd2 → disp_valid=1 two cycles later for exactly 4 cycles with disp_code=3, disp_pid=2; then 2 blank cycles; pending returns to 0.
- Held strobe: msg_sign high for 10 cycles, msg_out=5'd7 → exactly one display of 7; pending peaks at 1.
- Overflow: 6 rising edges (codes 1..6) 2 cycles apart while the first is displayed → codes 1..5 are displayed in order, code 6 is lost, overflow=1 until reset.
- Skip: during SHOW of code 9, assert skip on its 2nd display cycle → disp_valid falls on the next cycle, then the gap is 2 cycles, then the next entry is shown.
- Reset mid-SHOW with 3 entries pending → on the same edge all outputs are 0 and pending=0; after release the next message displays normally.
- MSG_RECEIVER_DUP_FILTER_EN: two pulses of code 4, PID 1, while the first entry is still queued → pending=1 and one display. Without the macro → pending=2 and two displays.
